// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Purpose  : Multi-port integer register file with a per-register scoreboard
//            and optional same-cycle write-to-read bypass. After every reset
//            a clear sequence zeroes one entry per cycle, then raises ready.
//            Register 0 always reads as zero and is never busy.
// Ports    : clk          system clock, rising-edge
//            rst          synchronous active-high reset
//            ready_o      clear sequence finished, file usable
//            rs_addr_i    NRP packed read addresses  (port p at [p*AW +: AW])
//            rs_data_o    NRP packed read data       (port p at [p*XLEN +: XLEN])
//            rs_busy_o    per-port busy status of the addressed register
//            we_i         write enable
//            rd_i         write address
//            rd_data_i    write data
//            iss_valid_i  issue strobe, marks iss_rd_i as having a producer
//            iss_rd_i     destination register of the issuing instruction
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready_o,
  input  logic [NRP*AW-1:0]   rs_addr_i,
  output logic [NRP*XLEN-1:0] rs_data_o,
  output logic [NRP-1:0]      rs_busy_o,
  input  logic                we_i,
  input  logic [AW-1:0]       rd_i,
  input  logic [XLEN-1:0]     rd_data_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i
);

  localparam logic [0:0]    C_ST_CLEAR = 1'b0;
  localparam logic [0:0]    C_ST_RUN   = 1'b1;
  localparam logic [AW-1:0] C_LAST_IDX = AW'(NREGS - 1);

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREGS];

  // Single array write port, shared between the clear sequence and RUN writes
  logic            w_arr_we;
  logic [AW-1:0]   w_arr_addr;
  logic [XLEN-1:0] w_arr_wdata;

  logic w_run;
  logic w_wr_ok;
  logic w_iss_ok;

  assign w_run    = (state_q == C_ST_RUN);
  assign w_wr_ok  = w_run && we_i && (rd_i != '0);
  assign w_iss_ok = w_run && iss_valid_i && (iss_rd_i != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    w_arr_we    = 1'b0;
    w_arr_addr  = rd_i;
    w_arr_wdata = rd_data_i;
    if (rst) begin
      state_d = C_ST_CLEAR;
      cnt_d   = '0;
      ready_d = 1'b0;
      busy_d  = '0;
    end else if (state_q == C_ST_CLEAR) begin
      w_arr_we    = 1'b1;
      w_arr_addr  = cnt_q;
      w_arr_wdata = '0;
      cnt_d       = cnt_q + 1'b1;
      if (cnt_q == C_LAST_IDX) begin
        state_d = C_ST_RUN;
        ready_d = 1'b1;
      end
    end else begin
      w_arr_we = w_wr_ok;
      if (w_wr_ok) begin
        busy_d[rd_i] = 1'b0;
      end
      // Applied after the clear so a same-edge issue wins: the new producer
      // owns the register even though its old value was just written.
      if (w_iss_ok) begin
        busy_d[iss_rd_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    ready_q <= ready_d;
    busy_q  <= busy_d;
  end

  // Array storage has no reset; it is defined by the clear sequence
  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      regs_q[w_arr_addr] <= w_arr_wdata;
    end
  end

  assign ready_o = ready_q;

  for (genvar p = 0; p < NRP; p++) begin : g_rd_port
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = rs_addr_i[p*AW +: AW];

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (w_run && (w_addr != '0)) begin
        if ((BYPASS != 0) && we_i && (rd_i == w_addr)) begin
          // Forwarded data is the producer's result, so it is never busy
          w_data = rd_data_i;
        end else begin
          w_data = regs_q[w_addr];
          w_busy = busy_q[w_addr];
        end
      end
    end

    assign rs_data_o[p*XLEN +: XLEN] = w_data;
    assign rs_busy_o[p]              = w_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Purpose  : Self-checking bench for regfile_mp_sb. Two instances (bypass on
//            and off) share one stimulus stream; a behavioural model of the
//            register file predicts every output each cycle, and directed
//            steps add constant-valued checks for the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRP   = 3;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                we = 1'b0;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       rd = '0;
  logic [AW-1:0]       iss_rd = '0;
  logic [XLEN-1:0]     rd_data = '0;
  logic [NRP*AW-1:0]   rs_addr = '0;

  logic                ready_b, ready_n;
  logic [NRP*XLEN-1:0] data_b, data_n;
  logic [NRP-1:0]      busy_b, busy_n;

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst(rst), .ready_o(ready_b),
    .rs_addr_i(rs_addr), .rs_data_o(data_b), .rs_busy_o(busy_b),
    .we_i(we), .rd_i(rd), .rd_data_i(rd_data),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .ready_o(ready_n),
    .rs_addr_i(rs_addr), .rs_data_o(data_n), .rs_busy_o(busy_n),
    .we_i(we), .rd_i(rd), .rd_data_i(rd_data),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              m_clr = 0;      // entries cleared since last reset
  int              n_cmp = 0;
  int              n_err = 0;
  bit              chk_en = 1'b0;

  function automatic bit m_ready();
    return (m_clr >= NREGS);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a, input bit byp);
    if (!m_ready() || a == 0) return '0;
    if (byp && we && int'(rd) == a) return rd_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (!m_ready() || a == 0) return 1'b0;
    if (byp && we && int'(rd) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_clr = 0;
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else if (!m_ready()) begin
      m_regs[m_clr] = '0;
      m_clr++;
    end else begin
      if (we && rd != 0) begin
        m_regs[rd] = rd_data;
        m_busy[rd] = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_byp", {31'b0, ready_b}, {31'b0, m_ready()});
    chk("ready_nb",  {31'b0, ready_n}, {31'b0, m_ready()});
    for (int p = 0; p < NRP; p++) begin
      int a;
      a = int'(rs_addr[p*AW +: AW]);
      chk($sformatf("data_byp[%0d] a=%0d", p, a), data_b[p*XLEN +: XLEN], exp_data(a, 1'b1));
      chk($sformatf("data_nb[%0d] a=%0d", p, a),  data_n[p*XLEN +: XLEN], exp_data(a, 1'b0));
      chk($sformatf("busy_byp[%0d] a=%0d", p, a), {31'b0, busy_b[p]}, {31'b0, exp_busy(a, 1'b1)});
      chk($sformatf("busy_nb[%0d] a=%0d", p, a),  {31'b0, busy_n[p]}, {31'b0, exp_busy(a, 1'b0)});
    end
  endtask

  task automatic probe();
    @(negedge clk);
    if (chk_en) check_all();
  endtask

  task automatic edge_adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    probe();
    edge_adv();
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; iss_valid = 1'b0;
    rd = '0; iss_rd = '0; rd_data = '0;
  endtask

  task automatic set_addr(input int a0, input int a1, input int a2);
    rs_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    set_addr(0, 0, 0);
    // First reset: DUT state is undefined before it, so no checks yet
    rst = 1'b1;
    step();
    chk_en = 1'b1;

    // Writes and issues during CLEAR must be ignored
    idle();
    we = 1'b1; rd = 5'd2; rd_data = 32'h55;
    iss_valid = 1'b1; iss_rd = 5'd2;
    set_addr(2, 2, 0);
    for (int i = 0; i < NREGS; i++) begin
      probe();
      chk("clear_ready_low", {31'b0, ready_b}, 32'd0);
      edge_adv();
    end
    idle();
    probe();
    chk("clear_ready_high", {31'b0, ready_b}, 32'd1);
    chk("clear_ignore_data", data_b[31:0], 32'd0);
    chk("clear_ignore_busy", {31'b0, busy_b[0]}, 32'd0);
    edge_adv();

    // Basic write / read on three ports
    we = 1'b1; rd = 5'd5; rd_data = 32'hDEADBEEF;
    step();
    idle();
    set_addr(5, 0, 5);
    probe();
    chk("basic_p0", data_b[0*XLEN +: XLEN], 32'hDEADBEEF);
    chk("basic_p1", data_b[1*XLEN +: XLEN], 32'h0);
    chk("basic_p2", data_b[2*XLEN +: XLEN], 32'hDEADBEEF);
    edge_adv();
    we = 1'b1; rd = 5'd0; rd_data = 32'h1234;
    set_addr(0, 0, 0);
    step();
    idle();
    probe();
    chk("r0_zero", data_b[31:0], 32'h0);
    edge_adv();

    // Bypass versus no bypass
    we = 1'b1; rd = 5'd7; rd_data = 32'h11;
    step();
    we = 1'b1; rd = 5'd7; rd_data = 32'h22;
    set_addr(7, 7, 7);
    probe();
    chk("bypass_on", data_b[31:0], 32'h22);
    chk("bypass_off", data_n[31:0], 32'h11);
    edge_adv();
    idle();
    probe();
    chk("bypass_off_next", data_n[31:0], 32'h22);
    edge_adv();

    // Scoreboard
    iss_valid = 1'b1; iss_rd = 5'd9;
    set_addr(9, 9, 0);
    step();
    idle();
    probe();
    chk("sb_busy_set", {31'b0, busy_b[0]}, 32'd1);
    edge_adv();
    we = 1'b1; rd = 5'd9; rd_data = 32'h99;
    probe();
    chk("sb_wcycle_byp", {31'b0, busy_b[0]}, 32'd0);
    chk("sb_wcycle_nb", {31'b0, busy_n[0]}, 32'd1);
    edge_adv();
    idle();
    probe();
    chk("sb_cleared", {31'b0, busy_n[0]}, 32'd0);
    edge_adv();
    we = 1'b1; rd = 5'd9; rd_data = 32'h77;
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    idle();
    probe();
    chk("sb_same_busy", {31'b0, busy_b[0]}, 32'd1);
    chk("sb_same_data", data_n[31:0], 32'h77);
    edge_adv();

    // Reset mid-operation, then again at clear count 10
    we = 1'b1; rd = 5'd3; rd_data = 32'hAA;
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd4;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_addr(3, 4, 0);
    for (int i = 0; i < NREGS; i++) begin
      probe();
      chk("rerst_ready_low", {31'b0, ready_n}, 32'd0);
      edge_adv();
    end
    probe();
    chk("rerst_ready_high", {31'b0, ready_n}, 32'd1);
    chk("rerst_r3", data_b[31:0], 32'h0);
    chk("rerst_busy4", {31'b0, busy_b[1]}, 32'd0);
    edge_adv();

    // Randomised traffic on a narrow address range to force collisions
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      we        = $urandom_range(0, 1);
      rd        = AW'($urandom_range(0, 7));
      rd_data   = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_rd    = AW'($urandom_range(0, 7));
      set_addr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
